mmio_responder: RTL and testbench

Memory-mapped I/O responder at the far end of the CPU's IORead/IOWrite strobes. When the decoder flags a load or store whose effective address lies in the top 1 KiB I/O window (address[31:10] all ones), this block services the access from the low 10 address bits. It owns the LED output register, a synchronized and debounced switch input, and a prescaled countdown timer with a sticky done flag. Read data is returned to the write-back mux one cycle after the strobe.

---
 rtl/io_pkg.sv | 40 ++++
 rtl/switch_debounce.sv | 55 +++++
 rtl/mmio_responder.sv | 132 +++++++++++++
 tb/tb_mmio_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared I/O window definitions: register offsets, TCTRL bit positions and the
// high-address pattern the decoder uses to recognise the 1 KiB I/O window.
package io_pkg;

    localparam logic [21:0] IO_WINDOW_HI = 22'h3FFFFF;

    localparam logic [9:0] IO_LED    = 10'h060;
    localparam logic [9:0] IO_SW     = 10'h070;
    localparam logic [9:0] IO_TLOAD  = 10'h080;
    localparam logic [9:0] IO_TCOUNT = 10'h084;
    localparam logic [9:0] IO_TSTAT  = 10'h088;
    localparam logic [9:0] IO_TCTRL  = 10'h08C;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SW,
        REG_TLOAD,
        REG_TCOUNT,
        REG_TSTAT,
        REG_TCTRL
    } io_reg_e;

    // Byte lanes are ignored: only the word offset selects a register.
    function automatic io_reg_e decode_offset(input logic [9:0] addr);
        case (addr & 10'h3FC)
            IO_LED:    return REG_LED;
            IO_SW:     return REG_SW;
            IO_TLOAD:  return REG_TLOAD;
            IO_TCOUNT: return REG_TCOUNT;
            IO_TSTAT:  return REG_TSTAT;
            IO_TCTRL:  return REG_TCTRL;
            default:   return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output follows the
// synchronized input only once it has held a new value for DEBOUNCE_CYCLES cycles.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int WIDTH           = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] sw_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // cand_q remembers last cycle's synchronized value so any change restarts the count.
    always_comb begin
        cand_d = sync2_q;
        sw_d   = sw_q;
        cnt_d  = '0;
        if (sync2_q != sw_q) begin
            if (sync2_q != cand_q) begin
                cnt_d = CW'(1);
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                sw_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            sw_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_o = sw_q;

endmodule

// File: rtl/mmio_responder.sv
// I/O window responder: LED register, debounced switches and a prescaled
// countdown timer with sticky done flag; read data is registered one cycle late.
module mmio_responder
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PRESCALE        = 100
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [9:0]  Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [23:0] SwitchIn,
    output logic [23:0] LedOut,
    output logic        TimerDone
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [23:0]   led_q, led_d;
    logic [31:0]   reload_q, reload_d;
    logic [31:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          done_q, done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [23:0]   sw_deb;
    logic [31:0]   rd_val;
    logic          running, tick, expire;
    io_reg_e       sel;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WIDTH          (24)
    ) u_switch_debounce (
        .clk_i (clock),
        .rst_ni(reset_n),
        .raw_i (SwitchIn),
        .sw_o  (sw_deb)
    );

    always_comb begin
        sel     = decode_offset(Addr);
        running = ctrl_q[TCTRL_EN] && (count_q != 32'd0);
        tick    = running && (presc_q == PW'(PRESCALE - 1));
        expire  = tick && (count_q == 32'd1);

        case (sel)
            REG_LED:    rd_val = {8'd0, led_q};
            REG_SW:     rd_val = {8'd0, sw_deb};
            REG_TLOAD:  rd_val = reload_q;
            REG_TCOUNT: rd_val = count_q;
            REG_TSTAT:  rd_val = {31'd0, done_q};
            REG_TCTRL:  rd_val = {30'd0, ctrl_q};
            default:    rd_val = 32'd0;
        endcase

        led_d    = led_q;
        reload_d = reload_q;
        count_d  = count_q;
        presc_d  = presc_q;
        ctrl_d   = ctrl_q;
        done_d   = done_q;
        rdata_d  = rdata_q;

        if (running) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
            if (count_q == 32'd1) begin
                count_d = ctrl_q[TCTRL_AUTO] ? reload_q : 32'd0;
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        // Expiry wins over a same-cycle TSTAT read so no event is lost.
        if (IORead && !IOWrite && sel == REG_TSTAT) begin
            done_d = 1'b0;
        end
        if (expire) begin
            done_d = 1'b1;
        end

        if (IOWrite) begin
            case (sel)
                REG_LED: led_d = WriteData[23:0];
                REG_TLOAD: begin
                    reload_d = WriteData;
                    count_d  = WriteData;
                    presc_d  = '0;
                end
                REG_TCTRL: ctrl_d = WriteData[1:0];
                default: ;
            endcase
        end

        if (IORead && IOWrite) begin
            rdata_d = 32'd0;
        end else if (IORead) begin
            rdata_d = rd_val;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_q    <= '0;
            reload_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            led_q    <= led_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ReadData  = rdata_q;
    assign LedOut    = led_q;
    assign TimerDone = done_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboarded bench for mmio_responder: expected read data is queued when a
// load is issued and compared when ReadData becomes valid.
`timescale 1ns/1ps
module tb_mmio_responder;
    import io_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        IORead = 1'b0;
    logic        IOWrite = 1'b0;
    logic [9:0]  Addr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [23:0] SwitchIn = '0;
    logic [23:0] LedOut;
    logic        TimerDone;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    mmio_responder #(
        .DEBOUNCE_CYCLES(8),
        .PRESCALE       (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .IORead   (IORead),
        .IOWrite  (IOWrite),
        .Addr     (Addr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .SwitchIn (SwitchIn),
        .LedOut   (LedOut),
        .TimerDone(TimerDone)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic io_write(input logic [9:0] a, input logic [31:0] d);
        Addr = a;
        WriteData = d;
        IOWrite = 1'b1;
        step(1);
        IOWrite = 1'b0;
        $display("[TB] write addr=%h data=%h", a, d);
    endtask

    task automatic io_read(input logic [9:0] a);
        Addr = a;
        IORead = 1'b1;
        step(1);
        IORead = 1'b0;
        $display("[TB] read  addr=%h data=%h", a, ReadData);
    endtask

    task automatic test_reset_state;
        step(2);
        tests_run++;
        if (ReadData !== 32'd0 || LedOut !== 24'd0 || TimerDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: ReadData=%h LedOut=%h TimerDone=%b, expected all 0",
                     ReadData, LedOut, TimerDone);
        end
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_led;
        io_write(IO_LED, 32'h00123456);
        tests_run++;
        if (LedOut !== 24'h123456) begin
            tests_failed++;
            $display("FAIL led_out: LedOut=%h expected 123456", LedOut);
        end
        exp_q.push_back(32'h00123456);
        io_read(IO_LED);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL led_read: ReadData=%h expected %h", ReadData, exp_v);
        end
        step(2);
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL read_hold: ReadData=%h expected %h", ReadData, exp_v);
        end
        exp_q.push_back(32'd0);
        io_read(10'h0F0);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL unmapped_read: ReadData=%h expected %h", ReadData, exp_v);
        end
        io_write(IO_TCOUNT, 32'h0000_0055);
        exp_q.push_back(32'd0);
        io_read(IO_TCOUNT);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL ro_write_ignored: ReadData=%h expected %h", ReadData, exp_v);
        end
    endtask

    task automatic test_switch;
        SwitchIn = 24'h00A5A5;
        step(9);
        exp_q.push_back(32'd0);
        io_read(IO_SW);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL sw_early: ReadData=%h expected %h", ReadData, exp_v);
        end
        exp_q.push_back(32'h0000A5A5);
        io_read(IO_SW);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL sw_settled: ReadData=%h expected %h", ReadData, exp_v);
        end
        for (int g = 0; g < 2; g++) begin
            SwitchIn = 24'h00A5A5 ^ 24'h0000FF;
            step((g == 0) ? 3 : 7);
            SwitchIn = 24'h00A5A5;
            step(20);
            exp_q.push_back(32'h0000A5A5);
            io_read(IO_SW);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (ReadData !== exp_v) begin
                tests_failed++;
                $display("FAIL sw_glitch_%0d: ReadData=%h expected %h", g, ReadData, exp_v);
            end
        end
    endtask

    task automatic test_timer_oneshot;
        io_write(IO_TCTRL, 32'd1);
        io_write(IO_TLOAD, 32'd3);
        step(11);
        tests_run++;
        if (TimerDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL oneshot_early: TimerDone=%b expected 0 at cycle 11", TimerDone);
        end
        step(1);
        tests_run++;
        if (TimerDone !== 1'b1) begin
            tests_failed++;
            $display("FAIL oneshot_done: TimerDone=%b expected 1 at cycle 12", TimerDone);
        end
        exp_q.push_back(32'd0);
        io_read(IO_TCOUNT);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL oneshot_count: ReadData=%h expected %h", ReadData, exp_v);
        end
        exp_q.push_back(32'd1);
        io_read(IO_TSTAT);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v || TimerDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL tstat_clear: ReadData=%h expected %h, TimerDone=%b expected 0",
                     ReadData, exp_v, TimerDone);
        end
    endtask

    task automatic test_timer_idle;
        io_write(IO_TCTRL, 32'd0);
        io_write(IO_TLOAD, 32'd5);
        step(30);
        exp_q.push_back(32'd5);
        io_read(IO_TCOUNT);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL frozen_count: ReadData=%h expected %h", ReadData, exp_v);
        end
        io_write(IO_TLOAD, 32'd0);
        io_write(IO_TCTRL, 32'd1);
        step(20);
        tests_run++;
        if (TimerDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_load: TimerDone=%b expected 0", TimerDone);
        end
    endtask

    task automatic test_timer_autoreload;
        io_write(IO_TCTRL, 32'd3);
        io_write(IO_TLOAD, 32'd2);
        step(7);
        tests_run++;
        if (TimerDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL auto_early: TimerDone=%b expected 0 at cycle 7", TimerDone);
        end
        step(1);
        tests_run++;
        if (TimerDone !== 1'b1) begin
            tests_failed++;
            $display("FAIL auto_done: TimerDone=%b expected 1 at cycle 8", TimerDone);
        end
        exp_q.push_back(32'd2);
        io_read(IO_TCOUNT);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL auto_reload: ReadData=%h expected %h", ReadData, exp_v);
        end
        exp_q.push_back(32'd1);
        io_read(IO_TSTAT);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL auto_tstat: ReadData=%h expected %h", ReadData, exp_v);
        end
        step(5);
        exp_q.push_back(32'd0);
        io_read(IO_TSTAT);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v || TimerDone !== 1'b1) begin
            tests_failed++;
            $display("FAIL tstat_at_expiry: ReadData=%h expected %h, TimerDone=%b expected 1",
                     ReadData, exp_v, TimerDone);
        end
    endtask

    task automatic test_both_strobes;
        exp_q.push_back(32'h00123456);
        io_read(IO_LED);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v) begin
            tests_failed++;
            $display("FAIL pre_both_read: ReadData=%h expected %h", ReadData, exp_v);
        end
        exp_q.push_back(32'd0);
        Addr = IO_LED;
        WriteData = 32'h00000077;
        IORead = 1'b1;
        IOWrite = 1'b1;
        step(1);
        IORead = 1'b0;
        IOWrite = 1'b0;
        $display("[TB] read+write addr=%h data=%h", IO_LED, 32'h77);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v || LedOut !== 24'h000077) begin
            tests_failed++;
            $display("FAIL both_strobes: ReadData=%h expected %h, LedOut=%h expected 000077",
                     ReadData, exp_v, LedOut);
        end
    endtask

    task automatic test_reset;
        io_write(IO_LED, 32'h00ABCDEF);
        exp_q.push_back(32'h00ABCDEF);
        io_read(IO_LED);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ReadData !== exp_v || LedOut !== 24'hABCDEF || TimerDone !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: ReadData=%h LedOut=%h TimerDone=%b, expected %h ABCDEF 1",
                     ReadData, LedOut, TimerDone, exp_v);
        end
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (ReadData !== 32'd0 || LedOut !== 24'd0 || TimerDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: ReadData=%h LedOut=%h TimerDone=%b, expected all 0",
                     ReadData, LedOut, TimerDone);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        test_reset_state();
        test_led();
        test_switch();
        test_timer_oneshot();
        test_timer_idle();
        test_timer_autoreload();
        test_both_strobes();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
